axi_exclusive_responder: RTL
============================

# axi_exclusive_responder

Single-beat AXI4 responder with a local word-addressed memory and a one-entry exclusive-access monitor. It is the target for the core's AXI master port in simulation and small FPGA builds. It services one transaction at a time and returns EXOKAY/OKAY so that the master's LR/SC and AMO read-modify-write retry protocol resolves correctly.

## Interface

Parameters:
- DEPTH_WORDS, 1024: memory size in 32-bit words; power of two.
- ID_WIDTH, 6: width of awid/bid/arid/rid.

Clock and reset: one clock; reset is asynchronous and active-high.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- awvalid, awready  in/out  1  write address handshake
- awaddr  in  32  byte address
- awlen  in  8  beats-1
- awburst  in  2  ignored
- awlock  in  1  exclusive write
- awid  in  ID_WIDTH  write ID
- wvalid, wready  in/out  1  write data handshake
- wdata  in  32  write data
- wstrb  in  4  byte enables
- bvalid  out  1  write response valid
- bready  in  1  write response accept
- bresp  out  2  write response code
- bid  out  ID_WIDTH  write response ID
- arvalid, arready  in/out  1  read address handshake
- araddr  in  32  byte address
- arlen  in  8  beats-1
- arburst  in  2  ignored
- arlock  in  1  exclusive read
- arid  in  ID_WIDTH  read ID
- rvalid  out  1  read data valid
- rready  in  1  read data accept
- rdata  out  32  read data
- rresp  out  2  read response code
- rlast  out  1  last beat
- rid  out  ID_WIDTH  read response ID

## Operation

- Word index = addr[31:2]. Out of range when index >= DEPTH_WORDS; the memory row used is index mod DEPTH_WORDS.
- Response codes: OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11. Error precedence: DECERR over SLVERR.
- FSM states:
  - IDLE: accepts AW, W or AR. Write has priority: arready=0 whenever awvalid|wvalid.
    - AW and W together: execute the write, go to WR_RESP.
    - AW only: go to WR_DATA.
    - W only: go to WR_ADDR.
    - AR (no write pending): go to RD_RESP.
  - WR_DATA: wready=1, awready=0. On the W handshake, execute the write and go to WR_RESP.
  - WR_ADDR: awready=1, wready=0. On the AW handshake, execute the write and go to WR_RESP.
  - WR_RESP: bvalid=1 and held stable until bready. Then go to IDLE.
  - RD_RESP: rvalid=1 and rlast=1, held stable until rready. Then go to IDLE.
- Readies are combinational from state: awready=(IDLE|WR_ADDR), wready=(IDLE|WR_DATA), arready=IDLE&~awvalid&~wvalid.
- Write execution:
  - awlen!=0: SLVERR, no memory update.
  - Out of range: DECERR, no update.
  - Exclusive (awlock=1): if the reservation is valid and matches the index, update bytes per wstrb and respond EXOKAY. Otherwise no update, respond OKAY. Either way the reservation is cleared.
  - Normal write: update per wstrb, respond OKAY. Clear the reservation if its index matches.
  - bid = captured awid.
- Read execution:
  - rdata = memory word, registered. rdata=0 on DECERR.
  - arlen!=0: single beat with SLVERR.
  - Exclusive in-range read: set reservation index and valid, respond EXOKAY.
  - Normal read: OKAY, reservation unchanged.
  - rid = arid.
- Single reservation; a new exclusive read overwrites it. Errored transactions do not touch the reservation, except that an errored exclusive write still clears it.

## Timing

- Write: last of the AW/W handshakes completes in cycle N. Memory and reservation update at the end of cycle N; bvalid=1 in cycle N+1.
- Read: AR handshake in cycle N; rvalid and rdata valid in cycle N+1.
- A read in the cycle after a write's B handshake sees the written data.
- Best-case throughput with bready=rready=1: one transaction per 2 cycles.
- Reset (asynchronous) values: state=IDLE, bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0, bid=0, rid=0, reservation valid=0. Readies follow from IDLE. Memory contents are not reset.
- Reset mid-transaction: any pending response is dropped. A memory update already performed persists.
- Captured AW/W fields are held internally; master-side changes after the handshake have no effect.

## Test plan

- Plain write then read: AW 0x100 and W 0xDEADBEEF with wstrb=F in the same cycle -> bvalid next cycle with bresp=00. AR 0x100 -> rdata=0xDEADBEEF, rresp=00, rlast=1, one cycle after AR.
- LR/SC success: arlock read at 0x40 -> rresp=01. awlock write 0x12345678 at 0x40 -> bresp=01; a read returns 0x12345678.
- SC failure: arlock read at 0x40, then normal write 0x1 to 0x40, then awlock write 0x2 to 0x40 -> bresp=00; a read returns 0x1.
- Split handshake: W alone (0xA5A5A5A5, wstrb=3) with AW held off for 3 cycles -> state WR_ADDR with arvalid ignored. AW 0x8 arrives -> bvalid the next cycle; only the low halfword is updated.
- Backpressure and errors: bready=0 for 4 cycles -> bvalid, bresp and bid stable throughout. AR with an index >= DEPTH_WORDS -> rresp=11, rdata=0. AW with awlen=3 -> bresp=10, memory unchanged.
- Async reset asserted while in WR_RESP -> bvalid=0 immediately, readies return to IDLE values, reservation invalid. A following awlock write -> bresp=00.

Source files
------------

// File: rtl/axi_exclusive_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_exclusive_responder
// Brief    : Single-beat AXI4 responder with word memory and a one-entry
//            exclusive-access monitor (EXOKAY/OKAY for LR/SC style retries).
// Revision : 1.0  initial release
// ============================================================================
module axi_exclusive_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ID_WIDTH    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [31:0]         awaddr,
    input  logic [7:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                awlock,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic                wvalid,
    output logic                wready,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    output logic [ID_WIDTH-1:0] bid,
    input  logic                arvalid,
    output logic                arready,
    input  logic [31:0]         araddr,
    input  logic [7:0]          arlen,
    input  logic [1:0]          arburst,
    input  logic                arlock,
    input  logic [ID_WIDTH-1:0] arid,
    output logic                rvalid,
    input  logic                rready,
    output logic [31:0]         rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic [ID_WIDTH-1:0] rid
);

    localparam int          c_IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_DEPTH  = 32'(DEPTH_WORDS);
    localparam logic [1:0]  c_OKAY   = 2'b00;
    localparam logic [1:0]  c_EXOKAY = 2'b01;
    localparam logic [1:0]  c_SLVERR = 2'b10;
    localparam logic [1:0]  c_DECERR = 2'b11;

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_WR_DATA = 3'd1;
    localparam logic [2:0] c_S_WR_ADDR = 3'd2;
    localparam logic [2:0] c_S_WR_RESP = 3'd3;
    localparam logic [2:0] c_S_RD_RESP = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;

    logic [31:0]         r_aw_addr;
    logic [7:0]          r_aw_len;
    logic                r_aw_lock;
    logic [ID_WIDTH-1:0] r_aw_id;
    logic [31:0]         r_w_data;
    logic [3:0]          r_w_strb;

    logic [31:0]         w_aw_addr;
    logic [7:0]          w_aw_len;
    logic                w_aw_lock;
    logic [ID_WIDTH-1:0] w_aw_id;
    logic [31:0]         w_w_data;
    logic [3:0]          w_w_strb;

    logic                w_wr_exec;
    logic                w_rd_exec;
    logic [29:0]         w_wr_idx;
    logic [29:0]         w_rd_idx;
    logic                w_wr_oor;
    logic                w_rd_oor;
    logic [c_IDX_W-1:0]  w_wr_row;
    logic [c_IDX_W-1:0]  w_rd_row;
    logic [31:0]         w_rd_word;

    logic                w_mem_we;
    logic                w_resv_clr;
    logic                w_resv_set;
    logic [1:0]          w_bresp;
    logic [1:0]          w_rresp;

    logic                r_resv_valid;
    logic [c_IDX_W-1:0]  r_resv_row;

    logic [1:0]          r_bresp;
    logic [ID_WIDTH-1:0] r_bid;
    logic [1:0]          r_rresp;
    logic [31:0]         r_rdata;
    logic [ID_WIDTH-1:0] r_rid;

    logic                w_unused;

    assign awready = (r_state == c_S_IDLE) || (r_state == c_S_WR_ADDR);
    assign wready  = (r_state == c_S_IDLE) || (r_state == c_S_WR_DATA);
    assign arready = (r_state == c_S_IDLE) && !awvalid && !wvalid;
    assign bvalid  = (r_state == c_S_WR_RESP);
    assign rvalid  = (r_state == c_S_RD_RESP);
    assign rlast   = (r_state == c_S_RD_RESP);
    assign bresp   = r_bresp;
    assign bid     = r_bid;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;
    assign rid     = r_rid;

    assign w_wr_exec = ((r_state == c_S_IDLE)    && awvalid && wvalid) ||
                       ((r_state == c_S_WR_DATA) && wvalid) ||
                       ((r_state == c_S_WR_ADDR) && awvalid);
    assign w_rd_exec = (r_state == c_S_IDLE) && arvalid && !awvalid && !wvalid;

    // The half of a split write that arrived first comes from the capture registers.
    always_comb begin
        w_aw_addr = awaddr;
        w_aw_len  = awlen;
        w_aw_lock = awlock;
        w_aw_id   = awid;
        w_w_data  = wdata;
        w_w_strb  = wstrb;
        if (r_state == c_S_WR_DATA) begin
            w_aw_addr = r_aw_addr;
            w_aw_len  = r_aw_len;
            w_aw_lock = r_aw_lock;
            w_aw_id   = r_aw_id;
        end
        if (r_state == c_S_WR_ADDR) begin
            w_w_data = r_w_data;
            w_w_strb = r_w_strb;
        end
    end

    assign w_wr_idx = w_aw_addr[31:2];
    assign w_rd_idx = araddr[31:2];
    assign w_wr_oor = ({2'b00, w_wr_idx} >= c_DEPTH);
    assign w_rd_oor = ({2'b00, w_rd_idx} >= c_DEPTH);
    assign w_wr_row = w_wr_idx[c_IDX_W-1:0];
    assign w_rd_row = w_rd_idx[c_IDX_W-1:0];

    // An exclusive write always consumes the reservation, even when it errors.
    always_comb begin
        w_bresp    = c_OKAY;
        w_mem_we   = 1'b0;
        w_resv_clr = w_aw_lock;
        if (w_wr_oor) begin
            w_bresp = c_DECERR;
        end else if (w_aw_len != 8'd0) begin
            w_bresp = c_SLVERR;
        end else if (w_aw_lock) begin
            if (r_resv_valid && (r_resv_row == w_wr_row)) begin
                w_mem_we = 1'b1;
                w_bresp  = c_EXOKAY;
            end
        end else begin
            w_mem_we   = 1'b1;
            w_resv_clr = r_resv_valid && (r_resv_row == w_wr_row);
        end
    end

    always_comb begin
        w_rresp    = c_OKAY;
        w_resv_set = 1'b0;
        if (w_rd_oor) begin
            w_rresp = c_DECERR;
        end else if (arlen != 8'd0) begin
            w_rresp = c_SLVERR;
        end else if (arlock) begin
            w_rresp    = c_EXOKAY;
            w_resv_set = w_rd_exec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (awvalid && wvalid) w_state_nxt = c_S_WR_RESP;
                else if (awvalid)      w_state_nxt = c_S_WR_DATA;
                else if (wvalid)       w_state_nxt = c_S_WR_ADDR;
                else if (arvalid)      w_state_nxt = c_S_RD_RESP;
            end
            c_S_WR_DATA: if (wvalid)  w_state_nxt = c_S_WR_RESP;
            c_S_WR_ADDR: if (awvalid) w_state_nxt = c_S_WR_RESP;
            c_S_WR_RESP: if (bready)  w_state_nxt = c_S_IDLE;
            c_S_RD_RESP: if (rready)  w_state_nxt = c_S_IDLE;
            default:                  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_addr <= '0;
            r_aw_len  <= '0;
            r_aw_lock <= 1'b0;
            r_aw_id   <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
        end else begin
            if ((r_state == c_S_IDLE) && awvalid) begin
                r_aw_addr <= awaddr;
                r_aw_len  <= awlen;
                r_aw_lock <= awlock;
                r_aw_id   <= awid;
            end
            if ((r_state == c_S_IDLE) && wvalid) begin
                r_w_data <= wdata;
                r_w_strb <= wstrb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resv_valid <= 1'b0;
            r_resv_row   <= '0;
        end else if (w_wr_exec && w_resv_clr) begin
            r_resv_valid <= 1'b0;
        end else if (w_resv_set) begin
            r_resv_valid <= 1'b1;
            r_resv_row   <= w_rd_row;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bresp <= c_OKAY;
            r_bid   <= '0;
            r_rresp <= c_OKAY;
            r_rdata <= '0;
            r_rid   <= '0;
        end else begin
            if (w_wr_exec) begin
                r_bresp <= w_bresp;
                r_bid   <= w_aw_id;
            end
            if (w_rd_exec) begin
                r_rresp <= w_rresp;
                r_rdata <= w_rd_oor ? 32'd0 : w_rd_word;
                r_rid   <= arid;
            end
        end
    end

    // One byte-wide array per lane so each lane maps onto a plain RAM.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] r_lane [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (w_wr_exec && w_mem_we && w_w_strb[b]) begin
                r_lane[w_wr_row] <= w_w_data[8*b +: 8];
            end
        end

        assign w_rd_word[8*b +: 8] = r_lane[w_rd_row];
    end

    assign w_unused = ^{awburst, arburst, w_aw_addr[1:0], araddr[1:0]};

endmodule
`default_nettype wire
